alu_serial_addsub_ctrl: RTL

//   Bit-serial add/subtract sequencer for the 8-bit CPU ALU. It drives a single 1-bit full adder
//   (two half adders plus an OR) over WIDTH clock cycles, LSB first, to add or subtract two operands.
//   It takes the place of a WIDTH-bit ripple adder where area matters more than latency.
//   The CPU control unit issues one operation with start and waits for the done pulse.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_serial_addsub_ctrl_if.sv | 26 ++
 rtl/HalfAdder_1B.sv | 10 +
 rtl/full_adder_1b.sv | 18 +
 rtl/alu_serial_addsub_ctrl.sv | 138 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract ALU sequencer: FSM state
// encoding and ALU op-code constants.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_serial_addsub_ctrl_if.sv
// Request/response bundle between the CPU control unit (master) and the
// serial add/subtract sequencer (slave).
interface alu_serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/HalfAdder_1B.sv
// One-bit half adder; two of these plus an OR gate make the serial full adder.
module HalfAdder_1B (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

// File: rtl/full_adder_1b.sv
// One-bit full adder built from two half adders; the only arithmetic element
// used by the serial sequencer.
module full_adder_1b (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic cout_o,
    output logic sum_o
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    HalfAdder_1B u_ha0 (.a_i(a_i),  .b_i(b_i),   .sum_o(s1_s),  .carry_o(c1_s));
    HalfAdder_1B u_ha1 (.a_i(s1_s), .b_i(cin_i), .sum_o(sum_o), .carry_o(c2_s));

    assign cout_o = c1_s | c2_s;
endmodule

// File: rtl/alu_serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: feeds one full adder LSB first over WIDTH
// cycles and presents registered result and flags with a one-cycle done pulse.
module alu_serial_addsub_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    alu_serial_addsub_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] sh_a_q,      sh_a_d;
    logic [WIDTH-1:0] sh_b_q,      sh_b_d;
    logic [WIDTH-1:0] sh_acc_q,    sh_acc_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q,  overflow_d;
    logic             zero_q,      zero_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic fa_sum_s;
    logic fa_cout_s;

    full_adder_1b u_fa (
        .a_i   (sh_a_q[0]),
        .b_i   (sh_b_q[0]),
        .cin_i (carry_q),
        .cout_o(fa_cout_s),
        .sum_o (fa_sum_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            sh_a_q      <= {WIDTH{1'b0}};
            sh_b_q      <= {WIDTH{1'b0}};
            sh_acc_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_acc_q    <= sh_acc_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_acc_d    = sh_acc_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    state_d = ST_RUN;
                    sh_a_d  = bus.a;
                    sh_b_d  = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                    carry_d = bus.op_sub;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                sh_acc_d = (sh_acc_q >> 1) | {fa_sum_s, {(WIDTH-1){1'b0}}};
                sh_a_d   = sh_a_q >> 1;
                sh_b_d   = sh_b_q >> 1;
                carry_d  = fa_cout_s;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this final step.
                    state_d     = ST_DONE;
                    result_d    = sh_acc_d;
                    carry_out_d = fa_cout_s;
                    overflow_d  = carry_q ^ fa_cout_s;
                    zero_d      = (sh_acc_d == {WIDTH{1'b0}});
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule
